// File: rtl/spike_event_packer.sv
// spike_event_packer
//  Turns the median detector's per-sample detection stream into spike events.
//  A per-channel refractory window keeps one spike from producing several
//  events; accepted events are packed as {time, channel, amplitude} and queued
//  in a FIFO behind a ready/valid master port. The input stream cannot be
//  stalled, so an accepted event that finds the FIFO full is dropped and counted.
//
//  Defaults below stand in for conf_pkg: 24 channels, 16-bit amplitude, 32-bit time.
//
//  Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   s_axis_time        sample time stamp of the current beat
//   s_axis_tchannel    channel of the current beat
//   s_axis_tdata       sample amplitude
//   s_axis_tvalid      detection flag for this beat
//   s_axis_tlast       last channel of frame (not used for events)
//   m_axis_tdata       event {time, channel, amplitude}
//   m_axis_tvalid      FIFO head valid
//   m_axis_tready      sink ready
//   fifo_full          FIFO holds FIFO_DEPTH events
//   drop_count         saturating count of accepted events lost to a full FIFO

// One refractory table entry: the time of the channel's last accepted event
// and whether that time is meaningful yet.
module spike_refractory_entry #(
  parameter int TIME_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [TIME_WIDTH-1:0] wr_time,
  output logic                  armed,
  output logic [TIME_WIDTH-1:0] last_time
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      last_time <= '0;
    end else if (wr_en) begin
      armed     <= 1'b1;
      last_time <= wr_time;
    end
  end
endmodule

module spike_event_packer #(
  parameter int CHANNEL_COUNT = 24,
  parameter int TIME_WIDTH    = 32,
  parameter int DATA_WIDTH    = 16,
  parameter int REFRACTORY    = 30,
  parameter int FIFO_DEPTH    = 16,
  localparam int CW = $clog2(CHANNEL_COUNT),
  localparam int EW = TIME_WIDTH + CW + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TIME_WIDTH-1:0] s_axis_time,
  input  logic [CW-1:0]         s_axis_tchannel,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic [EW-1:0]         m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  fifo_full,
  output logic [15:0]           drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [TIME_WIDTH-1:0] t;
    logic [CW-1:0]         ch;
    logic [DATA_WIDTH-1:0] amp;
  } ev_t;

  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  // Stage 1: register the beat. Out-of-range channels never become valid,
  // so they neither touch the table nor push.
  logic in_range;
  logic s1_vld;
  ev_t  s1;

  assign in_range = {1'b0, s_axis_tchannel} < (CW+1)'(CHANNEL_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else begin
      s1_vld <= s_axis_tvalid && in_range;
      s1     <= '{t: s_axis_time, ch: s_axis_tchannel, amp: s_axis_tdata};
    end
  end

  // Refractory table, one entry per channel
  logic [CHANNEL_COUNT-1:0]                 armed;
  logic [CHANNEL_COUNT-1:0][TIME_WIDTH-1:0] last_time;
  logic                                     accept;
  logic [TIME_WIDTH-1:0]                    dt;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_ref
      spike_refractory_entry #(.TIME_WIDTH(TIME_WIDTH)) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept && (s1.ch == CW'(gi))),
        .wr_time   (s1.t),
        .armed     (armed[gi]),
        .last_time (last_time[gi])
      );
    end
  endgenerate

  // Modular difference keeps the window correct across time-stamp wrap.
  assign dt     = s1.t - last_time[s1.ch];
  assign accept = s1_vld && (!armed[s1.ch] || (dt >= TIME_WIDTH'(REFRACTORY)));

  // Event FIFO. Valid/full are flops computed from the next occupancy, so the
  // head is visible one cycle after the push and never falls through.
  ev_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          tvalid_q, full_q;
  logic          pop, push, drop;

  assign pop  = tvalid_q && m_axis_tready;
  assign push = accept && (!full_q || pop);
  assign drop = accept && full_q && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (!push && pop) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tvalid_q   <= 1'b0;
      full_q     <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      tvalid_q <= count_nxt != '0;
      full_q   <= count_nxt == (AW+1)'(FIFO_DEPTH);
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1;
  end

  assign m_axis_tdata  = tvalid_q ? mem[rd_ptr] : '0;
  assign m_axis_tvalid = tvalid_q;
  assign fifo_full     = full_q;
endmodule

// File: tb/tb_spike_event_packer.sv
module tb_spike_event_packer;
  localparam int TW = 32, CH = 24, CW = 5, DW = 16, EW = TW + CW + DW;
  localparam int DEPTH = 16, REF = 30;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [TW-1:0] s_time = '0;
  logic [CW-1:0] s_ch = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_last = 1'b0;
  logic [EW-1:0] m_tdata;
  logic          m_tvalid, m_tready = 1'b0, fifo_full;
  logic [15:0]   drop_count;

  int n_vec = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spike_event_packer #(
    .CHANNEL_COUNT(CH), .TIME_WIDTH(TW), .DATA_WIDTH(DW),
    .REFRACTORY(REF), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_time(s_time), .s_axis_tchannel(s_ch), .s_axis_tdata(s_data),
    .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .fifo_full(fifo_full), .drop_count(drop_count)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] ev(int unsigned t, int ch, int d);
    return {t[TW-1:0], ch[CW-1:0], d[DW-1:0]};
  endfunction

  // Behavioural model: an event queue, a table of last accepted times and a
  // one-beat delay between the input and the accept decision.
  logic [EW-1:0] mq[$];
  bit            m_armed [CH];
  logic [TW-1:0] m_last  [CH];
  int            m_drop = 0;
  bit            stg_v = 0;
  logic [TW-1:0] stg_t;
  int            stg_ch;
  logic [DW-1:0] stg_d;

  // Events actually handed over by the DUT, with the cycle they appeared in.
  logic [EW-1:0] got[$];
  int            got_cyc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      foreach (m_armed[i]) begin m_armed[i] = 0; m_last[i] = '0; end
      m_drop = 0;
      stg_v  = 0;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_tdata", m_tdata, 0);
    end else begin
      chk("tvalid", m_tvalid, mq.size() != 0);
      if (mq.size() != 0) chk("tdata", m_tdata, mq[0]);
      chk("full", fifo_full, mq.size() == DEPTH);
      chk("drops", drop_count, m_drop);
      if (m_tvalid && m_tready) begin
        got.push_back(m_tdata);
        got_cyc.push_back(cyc);
      end
      if (mq.size() != 0 && m_tready) void'(mq.pop_front());
      if (stg_v) begin
        logic [TW-1:0] gap;
        gap = stg_t - m_last[stg_ch];
        if (!m_armed[stg_ch] || gap >= REF) begin
          m_armed[stg_ch] = 1;
          m_last[stg_ch]  = stg_t;
          if (mq.size() < DEPTH) mq.push_back(ev(stg_t, stg_ch, int'(stg_d)));
          else if (m_drop < 65535) m_drop++;
        end
      end
      stg_v  = s_valid && (int'(s_ch) < CH);
      stg_t  = s_time;
      stg_ch = int'(s_ch);
      stg_d  = s_data;
    end
  end

  task automatic beat(int ch, int unsigned t, int d);
    s_ch    = ch[CW-1:0];
    s_time  = t;
    s_data  = d[DW-1:0];
    s_last  = (ch == CH - 1);
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic got_is(string nm, int idx, logic [EW-1:0] e);
    if (idx < got.size()) chk(nm, got[idx], e);
    else begin
      n_vec++; n_err++;
      $display("FAIL %s: no beat at index %0d, expected %0h", nm, idx, e);
    end
  endtask

  initial begin
    int n0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // 1: single event, two-cycle latency, one-cycle valid
    m_tready = 1'b1;
    got.delete(); got_cyc.delete();
    n0 = cyc;
    beat(3, 100, 500);
    idle(4);
    chk("t1_count", got.size(), 1);
    got_is("t1_event", 0, ev(100, 3, 500));
    if (got_cyc.size() > 0) chk("t1_latency", got_cyc[0], n0 + 2);

    // 2: refractory suppression on one channel
    got.delete();
    beat(5, 10, 11); beat(5, 20, 12); beat(5, 40, 13); beat(5, 41, 14);
    idle(4);
    chk("t2_count", got.size(), 2);
    got_is("t2_ev0", 0, ev(10, 5, 11));
    got_is("t2_ev1", 1, ev(40, 5, 13));

    // 3: window measured across time wrap-around (21 rejected, 30 accepted)
    got.delete();
    beat(7, 32'hFFFF_FFF0, 1); beat(7, 32'h0000_0005, 2); beat(7, 32'h0000_000E, 3);
    idle(4);
    chk("t3_count", got.size(), 2);
    got_is("t3_ev0", 0, ev(32'hFFFF_FFF0, 7, 1));
    got_is("t3_ev1", 1, ev(32'h0000_000E, 7, 3));

    // 4: overflow with sink stalled, then drain in order
    m_tready = 1'b0;
    got.delete();
    for (int i = 0; i < 20; i++) beat(i, 1000 + i, 100 + i);
    idle(3);
    chk("t4_full", fifo_full, 1);
    chk("t4_drops", drop_count, 4);
    m_tready = 1'b1;
    idle(20);
    chk("t4_count", got.size(), 16);
    for (int i = 0; i < 16; i++) got_is("t4_order", i, ev(1000 + i, i, 100 + i));

    // 5: push and pop together while full -> no drop, order kept
    m_tready = 1'b0;
    got.delete();
    for (int i = 0; i < 16; i++) beat(i, 2000 + i, 200 + i);
    idle(2);
    chk("t5_full_pre", fifo_full, 1);
    beat(20, 2100, 77);
    m_tready = 1'b1;
    idle(1);
    m_tready = 1'b0;
    chk("t5_full_post", fifo_full, 1);
    chk("t5_drops", drop_count, 4);
    m_tready = 1'b1;
    idle(20);
    chk("t5_count", got.size(), 17);
    got_is("t5_first", 0, ev(2000, 0, 200));
    got_is("t5_mid", 15, ev(2015, 15, 215));
    got_is("t5_last", 16, ev(2100, 20, 77));

    // 6: out-of-range channel ignored; reset drops buffered events and disarms
    m_tready = 1'b0;
    got.delete();
    for (int i = 0; i < 5; i++) beat(8 + i, 3000 + i, 300 + i);
    beat(25, 3100, 9);
    idle(3);
    chk("t6_tvalid_pre", m_tvalid, 1);
    chk("t6_drops_pre", drop_count, 4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_tvalid, 0);
    chk("t6_rst_full", fifo_full, 0);
    chk("t6_rst_drops", drop_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    beat(8, 3001, 99);
    idle(4);
    chk("t6_count", got.size(), 1);
    got_is("t6_rearm", 0, ev(3001, 8, 99));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
